// File: rtl/mem_s2_arbiter.sv
// mem_s2_arbiter: arbiter and sequencer for port s2 of the shared Nios/Pi
// on-chip memory. Requester A is the Pi SPI bridge, requester B is the
// accelerometer sample writer. All memory-side signals are driven from
// registers. Read data comes back on the requester's rdata, with an rvalid
// pulse two cycles after the grant cycle.
//
// Build option: define MEM_ARB_FIXED_PRIO_EN to give port A absolute
// priority on simultaneous requests. When it is undefined (the default),
// arbitration is round-robin on the most recently granted port.

module mem_s2_arbiter #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,

    // Requester A (Pi SPI bridge)
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W-1:0]     a_wdata,
    input  logic [DATA_W/8-1:0]   a_be,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_W-1:0]     a_rdata,

    // Requester B (accelerometer sample writer)
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [DATA_W-1:0]     b_wdata,
    input  logic [DATA_W/8-1:0]   b_be,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_W-1:0]     b_rdata,

    // Memory port s2
    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_chipselect,
    output logic                  mem_clken,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    input  logic [DATA_W-1:0]     mem_readdata
);

    localparam int unsigned BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StCapture
    } state_e;

    state_e state_q, state_d;

    // Arbitration result for the current cycle (only meaningful in StIdle)
    logic win_a, win_b;

    // Port that owns the access in flight: 1 = B, 0 = A
    logic owner_b_q, owner_b_d;

    // Registered outputs
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_writedata_q, mem_writedata_d;
    logic [BE_W-1:0]   mem_byteenable_q, mem_byteenable_d;
    logic              mem_chipselect_q, mem_chipselect_d;
    logic              mem_write_q, mem_write_d;
    logic              a_gnt_q, a_gnt_d;
    logic              b_gnt_q, b_gnt_d;
    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

`ifdef MEM_ARB_FIXED_PRIO_EN

    // Fixed priority: A wins any request it makes
    always_comb begin
        win_a = a_req;
        win_b = b_req & ~a_req;
    end

`else

    // Most recently granted port: 1 = B, 0 = A. Resets to B so A wins the first tie.
    logic last_b_q, last_b_d;

    // Round-robin: on a tie, grant the port that was not granted last
    always_comb begin
        win_a    = a_req & (~b_req | last_b_q);
        win_b    = b_req & ~win_a;
        last_b_d = last_b_q;
        if ((state_q == StIdle) && (a_req || b_req)) begin
            last_b_d = win_b;
        end
    end

    // Round-robin history register
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            last_b_q <= 1'b1;
        end else begin
            last_b_q <= last_b_d;
        end
    end

`endif

    // FSM state register
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: writes take one access cycle, reads add a capture cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (a_req || b_req) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                state_d = mem_write_q ? StIdle : StCapture;
            end
            StCapture: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM outputs: next values for the registered grant, memory and read-return signals
    always_comb begin
        // Address/data/byte enables hold when idle; only chipselect/write qualify an access
        mem_address_d    = mem_address_q;
        mem_writedata_d  = mem_writedata_q;
        mem_byteenable_d = mem_byteenable_q;
        mem_chipselect_d = 1'b0;
        mem_write_d      = 1'b0;
        a_gnt_d          = 1'b0;
        b_gnt_d          = 1'b0;
        a_rvalid_d       = 1'b0;
        b_rvalid_d       = 1'b0;
        a_rdata_d        = a_rdata_q;
        b_rdata_d        = b_rdata_q;
        owner_b_d        = owner_b_q;

        case (state_q)
            StIdle: begin
                if (win_a) begin
                    mem_address_d    = a_addr;
                    mem_writedata_d  = a_wdata;
                    mem_byteenable_d = a_be;
                    mem_chipselect_d = 1'b1;
                    mem_write_d      = a_we;
                    a_gnt_d          = 1'b1;
                    owner_b_d        = 1'b0;
                end else if (win_b) begin
                    mem_address_d    = b_addr;
                    mem_writedata_d  = b_wdata;
                    mem_byteenable_d = b_be;
                    mem_chipselect_d = 1'b1;
                    mem_write_d      = b_we;
                    b_gnt_d          = 1'b1;
                    owner_b_d        = 1'b1;
                end
            end
            StAccess: begin
                // Access completes at the end of this cycle; defaults drop the strobes
            end
            StCapture: begin
                // Memory read data is valid in this cycle
                if (owner_b_q) begin
                    b_rdata_d  = mem_readdata;
                    b_rvalid_d = 1'b1;
                end else begin
                    a_rdata_d  = mem_readdata;
                    a_rvalid_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Output and ownership registers
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            mem_address_q    <= '0;
            mem_writedata_q  <= '0;
            mem_byteenable_q <= '0;
            mem_chipselect_q <= 1'b0;
            mem_write_q      <= 1'b0;
            a_gnt_q          <= 1'b0;
            b_gnt_q          <= 1'b0;
            a_rvalid_q       <= 1'b0;
            b_rvalid_q       <= 1'b0;
            a_rdata_q        <= '0;
            b_rdata_q        <= '0;
            owner_b_q        <= 1'b0;
        end else begin
            mem_address_q    <= mem_address_d;
            mem_writedata_q  <= mem_writedata_d;
            mem_byteenable_q <= mem_byteenable_d;
            mem_chipselect_q <= mem_chipselect_d;
            mem_write_q      <= mem_write_d;
            a_gnt_q          <= a_gnt_d;
            b_gnt_q          <= b_gnt_d;
            a_rvalid_q       <= a_rvalid_d;
            b_rvalid_q       <= b_rvalid_d;
            a_rdata_q        <= a_rdata_d;
            b_rdata_q        <= b_rdata_d;
            owner_b_q        <= owner_b_d;
        end
    end

    assign mem_address    = mem_address_q;
    assign mem_writedata  = mem_writedata_q;
    assign mem_byteenable = mem_byteenable_q;
    assign mem_chipselect = mem_chipselect_q;
    assign mem_write      = mem_write_q;
    assign mem_clken      = 1'b1;
    assign a_gnt          = a_gnt_q;
    assign b_gnt          = b_gnt_q;
    assign a_rvalid       = a_rvalid_q;
    assign b_rvalid       = b_rvalid_q;
    assign a_rdata        = a_rdata_q;
    assign b_rdata        = b_rdata_q;

endmodule

// File: tb/tb_mem_s2_arbiter.sv
// tb_mem_s2_arbiter: directed bench for mem_s2_arbiter with a small model
// of the s2 memory (registered read data, byte-enabled writes).
// Honours MEM_ARB_FIXED_PRIO_EN for the grant-order expectations.

module tb_mem_s2_arbiter;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 32;

    logic                clk_clk = 1'b0;
    logic                reset_reset_n;
    logic                a_req, a_we, b_req, b_we;
    logic [ADDR_W-1:0]   a_addr, b_addr;
    logic [DATA_W-1:0]   a_wdata, b_wdata;
    logic [DATA_W/8-1:0] a_be, b_be;
    logic                a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DATA_W-1:0]   a_rdata, b_rdata;
    logic [ADDR_W-1:0]   mem_address;
    logic                mem_chipselect, mem_clken, mem_write;
    logic [DATA_W-1:0]   mem_writedata;
    logic [DATA_W/8-1:0] mem_byteenable;
    logic [DATA_W-1:0]   mem_readdata;

    int checks = 0;
    int errors = 0;

    always #5 clk_clk = ~clk_clk;

    mem_s2_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .a_req          (a_req),
        .a_we           (a_we),
        .a_addr         (a_addr),
        .a_wdata        (a_wdata),
        .a_be           (a_be),
        .a_gnt          (a_gnt),
        .a_rvalid       (a_rvalid),
        .a_rdata        (a_rdata),
        .b_req          (b_req),
        .b_we           (b_we),
        .b_addr         (b_addr),
        .b_wdata        (b_wdata),
        .b_be           (b_be),
        .b_gnt          (b_gnt),
        .b_rvalid       (b_rvalid),
        .b_rdata        (b_rdata),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_byteenable (mem_byteenable),
        .mem_readdata   (mem_readdata)
    );

    // Memory model: registered read data, available the cycle after the access
    logic [DATA_W-1:0] mem [128];
    always @(posedge clk_clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int i = 0; i < 4; i++) begin
                    if (mem_byteenable[i]) mem[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
                end
            end else begin
                mem_readdata <= mem[mem_address];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle; sample and drive 1 ns after the rising edge
    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic set_a(input logic we, input logic [6:0] addr, input logic [31:0] wd,
                         input logic [3:0] be);
        a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; a_be = be;
    endtask

    task automatic set_b(input logic we, input logic [6:0] addr, input logic [31:0] wd,
                         input logic [3:0] be);
        b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; b_be = be;
    endtask

    initial begin
        reset_reset_n = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
        mem_readdata = '0;
        tick();
        tick();

        // Reset state
        check("rst_a_gnt", 32'(a_gnt), 0);
        check("rst_b_gnt", 32'(b_gnt), 0);
        check("rst_a_rvalid", 32'(a_rvalid), 0);
        check("rst_b_rvalid", 32'(b_rvalid), 0);
        check("rst_cs", 32'(mem_chipselect), 0);
        check("rst_write", 32'(mem_write), 0);
        check("rst_addr", 32'(mem_address), 0);
        check("rst_wdata", mem_writedata, 0);
        check("rst_be", 32'(mem_byteenable), 0);
        check("rst_a_rdata", a_rdata, 0);
        check("rst_b_rdata", b_rdata, 0);
        check("rst_clken", 32'(mem_clken), 1);
        reset_reset_n = 1'b1;

        // Write A alone
        set_a(1'b1, 7'h05, 32'hDEADBEEF, 4'hF);
        tick();
        check("wa_a_gnt", 32'(a_gnt), 1);
        check("wa_b_gnt", 32'(b_gnt), 0);
        check("wa_cs", 32'(mem_chipselect), 1);
        check("wa_write", 32'(mem_write), 1);
        check("wa_addr", 32'(mem_address), 32'h05);
        check("wa_wdata", mem_writedata, 32'hDEADBEEF);
        check("wa_be", 32'(mem_byteenable), 32'hF);
        a_req = 1'b0;
        tick();
        check("wa_cs_drop", 32'(mem_chipselect), 0);
        check("wa_gnt_drop", 32'(a_gnt), 0);

        // Read B alone
        set_b(1'b0, 7'h05, 32'h0, 4'h0);
        tick();
        check("rb_b_gnt", 32'(b_gnt), 1);
        check("rb_cs", 32'(mem_chipselect), 1);
        check("rb_write", 32'(mem_write), 0);
        b_req = 1'b0;
        tick();
        check("rb_capture_rvalid", 32'(b_rvalid), 0);
        check("rb_capture_cs", 32'(mem_chipselect), 0);
        tick();
        check("rb_b_rvalid", 32'(b_rvalid), 1);
        check("rb_b_rdata", b_rdata, 32'hDEADBEEF);
        check("rb_a_rvalid", 32'(a_rvalid), 0);
        tick();
        check("rb_rvalid_pulse", 32'(b_rvalid), 0);

        // Preload word 0x20, then partial write and read back
        set_a(1'b1, 7'h20, 32'h11111111, 4'hF);
        tick();
        a_req = 1'b0;
        tick();
        set_a(1'b1, 7'h20, 32'h0000ABCD, 4'h3);
        tick();
        check("be_a_gnt", 32'(a_gnt), 1);
        check("be_be", 32'(mem_byteenable), 32'h3);
        a_req = 1'b0;
        tick();
        set_a(1'b0, 7'h20, 32'h0, 4'h0);
        tick();
        check("be_rd_gnt", 32'(a_gnt), 1);
        a_req = 1'b0;
        tick();
        tick();
        check("be_rd_rvalid", 32'(a_rvalid), 1);
        check("be_rd_rdata", a_rdata, 32'h1111ABCD);

        // Reset during CAPTURE of a B read
        set_b(1'b0, 7'h20, 32'h0, 4'h0);
        tick();
        check("rc_b_gnt", 32'(b_gnt), 1);
        b_req = 1'b0;
        tick();
        reset_reset_n = 1'b0;
        tick();
        check("rc_b_rvalid", 32'(b_rvalid), 0);
        check("rc_b_rdata", b_rdata, 0);
        check("rc_a_rdata", a_rdata, 0);
        check("rc_addr", 32'(mem_address), 0);
        check("rc_be", 32'(mem_byteenable), 0);
        check("rc_wdata", mem_writedata, 0);
        reset_reset_n = 1'b1;
        tick();
        check("rc_no_late_rvalid", 32'(b_rvalid), 0);
        set_a(1'b1, 7'h01, 32'hAAAA0001, 4'hF);
        set_b(1'b1, 7'h02, 32'hBBBB0002, 4'hF);
        tick();
        check("rc_tie_a_gnt", 32'(a_gnt), 1);
        check("rc_tie_b_gnt", 32'(b_gnt), 0);
        check("rc_tie_addr", 32'(mem_address), 32'h01);
        a_req = 1'b0;
        tick();
        tick();
        check("rc_then_b_gnt", 32'(b_gnt), 1);
        b_req = 1'b0;
        tick();

        // Back-to-back: B write then A read of the same word
        set_b(1'b1, 7'h10, 32'hCAFEF00D, 4'hF);
        tick();
        check("bb_b_gnt", 32'(b_gnt), 1);
        b_req = 1'b0;
        set_a(1'b0, 7'h10, 32'h0, 4'h0);
        tick();
        check("bb_gap_a_gnt", 32'(a_gnt), 0);
        tick();
        check("bb_a_gnt", 32'(a_gnt), 1);
        a_req = 1'b0;
        tick();
        tick();
        check("bb_a_rvalid", 32'(a_rvalid), 1);
        check("bb_a_rdata", a_rdata, 32'hCAFEF00D);

        // Both ports request continuously from reset
        reset_reset_n = 1'b0;
        tick();
        set_a(1'b1, 7'h03, 32'h00000003, 4'hF);
        set_b(1'b1, 7'h04, 32'h00000004, 4'hF);
        reset_reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic exp_a, exp_b;
            tick();
            exp_a = 1'b0;
            exp_b = 1'b0;
            if ((k % 2) == 0) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                exp_a = 1'b1;
`else
                exp_a = ((k / 2) % 2) == 0;
                exp_b = !exp_a;
`endif
            end
            check($sformatf("rr_a_gnt_%0d", k), 32'(a_gnt), 32'(exp_a));
            check($sformatf("rr_b_gnt_%0d", k), 32'(b_gnt), 32'(exp_b));
        end
        a_req = 1'b0;
        b_req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
